// File: rtl/nds_ecc_ram_init_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nds_ecc_ram_ctrl_pkg
// Brief   : Shared types for the ECC RAM init/request controller.
// Revision: 1.0 - initial release
// ============================================================================
package nds_ecc_ram_ctrl_pkg;

  // Controller phases: waiting after reset, sweeping INIT_VALUE, serving requests.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    READY = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/nds_ecc_ram_init_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : nds_ecc_ram_init_ctrl_if
// Brief   : Bundles the init control, request/response and RAM-side signals.
//           slave = controller view, master = cluster/RAM environment view.
// Revision: 1.0 - initial release
// ============================================================================
interface nds_ecc_ram_init_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
);
  import nds_ecc_ram_ctrl_pkg::*;

  logic                  i_init_start;
  logic                  o_init_busy;
  logic                  o_init_done;
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic                  i_req_we;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic [DATA_WIDTH-1:0] i_req_wdata;
  logic                  o_rsp_valid;
  logic [DATA_WIDTH-1:0] o_rsp_rdata;
  logic                  o_ram_cs;
  logic                  o_ram_we;
  logic [ADDR_WIDTH-1:0] o_ram_addr;
  logic [DATA_WIDTH-1:0] o_ram_din;
  logic [DATA_WIDTH-1:0] i_ram_dout;

  modport slave (
    input  i_init_start, i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_ram_dout,
    output o_init_busy, o_init_done, o_req_ready, o_rsp_valid, o_rsp_rdata,
           o_ram_cs, o_ram_we, o_ram_addr, o_ram_din
  );

  modport master (
    output i_init_start, i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_ram_dout,
    input  o_init_busy, o_init_done, o_req_ready, o_rsp_valid, o_rsp_rdata,
           o_ram_cs, o_ram_we, o_ram_addr, o_ram_din
  );

endinterface
`default_nettype wire

// File: rtl/nds_ecc_ram_init_ctrl_rsp_pipe.sv
`default_nettype none
// ============================================================================
// Module  : nds_ecc_ram_rsp_pipe
// Brief   : LATENCY-deep valid shift register; an issue strobe reappears as
//           a retire strobe exactly LATENCY cycles later.
// Revision: 1.0 - initial release
// ============================================================================
module nds_ecc_ram_rsp_pipe
  import nds_ecc_ram_ctrl_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic issue,
  output logic      retire
);

  logic [LATENCY-1:0] stage;

  generate
    if (LATENCY == 1) begin : g_single
      // Single stage: the strobe is simply delayed by one cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage <= '0;
        else        stage <= issue;
      end
    end else begin : g_multi
      // Multi stage: shift the strobe toward the MSB once per cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage <= '0;
        else        stage <= {stage[LATENCY-2:0], issue};
      end
    end
  endgenerate

  assign retire = stage[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/nds_ecc_ram_init_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : nds_ecc_ram_init_ctrl
// Brief   : Requester-side controller for a 1RW ECC RAM. Sweeps INIT_VALUE
//           over every word after reset (or on request) so check bits are
//           valid, then forwards one request per cycle and returns read data
//           aligned to the RAM read latency.
// Revision: 1.0 - initial release
// ============================================================================
module nds_ecc_ram_init_ctrl
  import nds_ecc_ram_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 64,
  parameter int                    ADDR_WIDTH   = 5,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0,
  parameter bit                    AUTO_INIT    = 1'b1
) (
  input  wire logic              i_clk,
  input  wire logic              i_rst_n,
  nds_ecc_ram_init_ctrl_if.slave bus
);

  // All-ones address is NUM_WORDS-1; the sweep ends on this compare rather
  // than on counter wrap.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_e                state;
  state_e                next_state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  last_word;
  logic                  init_done;
  logic                  init_busy;
  logic                  req_ready;
  logic                  accept;
  logic                  rsp_valid;
  logic                  ram_cs;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;

  assign last_word = (cnt == LAST_ADDR);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next state plus RAM-side mux, selected by the state register only.
  always_comb begin
    next_state = state;
    init_busy  = 1'b0;
    req_ready  = 1'b0;
    accept     = 1'b0;
    ram_cs     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_din    = '0;
    case (state)
      IDLE: begin
        if (AUTO_INIT || bus.i_init_start) next_state = INIT;
      end
      INIT: begin
        init_busy = 1'b1;
        ram_cs    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = cnt;
        ram_din   = INIT_VALUE;
        if (last_word) next_state = READY;
      end
      READY: begin
        // An init request takes priority; the pending request waits upstream.
        req_ready = ~bus.i_init_start;
        accept    = bus.i_req_valid & req_ready;
        if (accept) begin
          ram_cs   = 1'b1;
          ram_we   = bus.i_req_we;
          ram_addr = bus.i_req_addr;
          ram_din  = bus.i_req_wdata;
        end
        if (bus.i_init_start) next_state = INIT;
      end
      default: next_state = IDLE;
    endcase
  end

  // Sweep counter and sticky done flag; init_start is ignored mid-sweep.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt       <= '0;
      init_done <= 1'b0;
    end else if (state == INIT) begin
      if (last_word) begin
        cnt       <= '0;
        init_done <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (bus.i_init_start) begin
      cnt       <= '0;
      init_done <= 1'b0;
    end
  end

  nds_ecc_ram_rsp_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_rsp_pipe (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .issue  (accept & ~bus.i_req_we),
    .retire (rsp_valid)
  );

  assign bus.o_init_busy = init_busy;
  assign bus.o_init_done = init_done;
  assign bus.o_req_ready = req_ready;
  assign bus.o_ram_cs    = ram_cs;
  assign bus.o_ram_we    = ram_we;
  assign bus.o_ram_addr  = ram_addr;
  assign bus.o_ram_din   = ram_din;
  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rsp_rdata = rsp_valid ? bus.i_ram_dout : '0;

endmodule
`default_nettype wire

// File: tb/tb_nds_ecc_ram_init_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_nds_ecc_ram_init_ctrl
// Brief   : Directed bench. dut_a (latency 1) and dut_b (latency 3) share
//           stimulus with auto-init; dut_c uses AUTO_INIT=0. Each has a
//           behavioural RAM; read responses are scoreboarded.
// Revision: 1.0 - initial release
// ============================================================================
module tb_nds_ecc_ram_init_ctrl;

  localparam int          DW     = 64;
  localparam int          AW     = 5;
  localparam int          NW     = 32;
  localparam logic [63:0] GARB   = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] C_INIT = 64'h5A5A_0F0F_C3C3_9696;

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  logic          start, valid, we, c_start;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nds_ecc_ram_init_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
  nds_ecc_ram_init_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();
  nds_ecc_ram_init_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_c ();

  nds_ecc_ram_init_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1),
    .INIT_VALUE('0), .AUTO_INIT(1'b1)) dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_a));
  nds_ecc_ram_init_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(3),
    .INIT_VALUE('0), .AUTO_INIT(1'b1)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_b));
  nds_ecc_ram_init_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1),
    .INIT_VALUE(C_INIT), .AUTO_INIT(1'b0)) dut_c (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_c));

  assign bus_a.i_init_start = start;
  assign bus_a.i_req_valid  = valid;
  assign bus_a.i_req_we     = we;
  assign bus_a.i_req_addr   = addr;
  assign bus_a.i_req_wdata  = wdata;
  assign bus_b.i_init_start = start;
  assign bus_b.i_req_valid  = valid;
  assign bus_b.i_req_we     = we;
  assign bus_b.i_req_addr   = addr;
  assign bus_b.i_req_wdata  = wdata;
  assign bus_c.i_init_start = c_start;
  assign bus_c.i_req_valid  = 1'b0;
  assign bus_c.i_req_we     = 1'b0;
  assign bus_c.i_req_addr   = '0;
  assign bus_c.i_req_wdata  = '0;

  // Behavioural single-port RAMs with the matching read latency.
  logic [DW-1:0] mem_a [NW];
  logic [DW-1:0] mem_b [NW];
  logic [DW-1:0] mem_c [NW];
  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b [3];
  logic [DW-1:0] rd_c;

  always @(posedge clk) begin
    if (bus_a.o_ram_cs && bus_a.o_ram_we) mem_a[bus_a.o_ram_addr] <= bus_a.o_ram_din;
    rd_a <= (bus_a.o_ram_cs && !bus_a.o_ram_we) ? mem_a[bus_a.o_ram_addr] : GARB;
    if (bus_b.o_ram_cs && bus_b.o_ram_we) mem_b[bus_b.o_ram_addr] <= bus_b.o_ram_din;
    rd_b[0] <= (bus_b.o_ram_cs && !bus_b.o_ram_we) ? mem_b[bus_b.o_ram_addr] : GARB;
    rd_b[1] <= rd_b[0];
    rd_b[2] <= rd_b[1];
    if (bus_c.o_ram_cs && bus_c.o_ram_we) mem_c[bus_c.o_ram_addr] <= bus_c.o_ram_din;
    rd_c <= (bus_c.o_ram_cs && !bus_c.o_ram_we) ? mem_c[bus_c.o_ram_addr] : GARB;
  end

  assign bus_a.i_ram_dout = rd_a;
  assign bus_b.i_ram_dout = rd_b[2];
  assign bus_c.i_ram_dout = rd_c;

  logic [138:0] outs_a, outs_b, outs_c;
  assign outs_a = {bus_a.o_init_busy, bus_a.o_init_done, bus_a.o_req_ready, bus_a.o_rsp_valid,
                   bus_a.o_ram_cs, bus_a.o_ram_we, bus_a.o_ram_addr, bus_a.o_ram_din, bus_a.o_rsp_rdata};
  assign outs_b = {bus_b.o_init_busy, bus_b.o_init_done, bus_b.o_req_ready, bus_b.o_rsp_valid,
                   bus_b.o_ram_cs, bus_b.o_ram_we, bus_b.o_ram_addr, bus_b.o_ram_din, bus_b.o_rsp_rdata};
  assign outs_c = {bus_c.o_init_busy, bus_c.o_init_done, bus_c.o_req_ready, bus_c.o_rsp_valid,
                   bus_c.o_ram_cs, bus_c.o_ram_we, bus_c.o_ram_addr, bus_c.o_ram_din, bus_c.o_rsp_rdata};

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_read(input logic [63:0] d);
    qa.push_back('{data: d, due: cyc + 1});
    qb.push_back('{data: d, due: cyc + 3});
  endtask

  // Checks n consecutive sweep cycles on dut_a/dut_b starting at address 0.
  task automatic sweep_ab(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s_a_%0d", tag, i),
          {bus_a.o_ram_cs, bus_a.o_ram_we, bus_a.o_init_busy, bus_a.o_req_ready,
           bus_a.o_init_done, bus_a.o_ram_addr, bus_a.o_ram_din},
          {5'b11100, AW'(i), 64'd0});
      chk($sformatf("%s_b_%0d", tag, i),
          {bus_b.o_ram_cs, bus_b.o_ram_we, bus_b.o_init_busy, bus_b.o_req_ready,
           bus_b.o_init_done, bus_b.o_ram_addr, bus_b.o_ram_din},
          {5'b11100, AW'(i), 64'd0});
      step();
    end
  endtask

  // Response scoreboard: compare data and arrival cycle, flag strays/misses.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus_a.o_rsp_valid && qa.size() > 0) begin
        ea = qa.pop_front();
        chk("rsp_a_data", bus_a.o_rsp_rdata, ea.data);
        chk("rsp_a_cycle", cyc, ea.due);
      end else begin
        chk("rsp_a_idle", {bus_a.o_rsp_valid, bus_a.o_rsp_rdata}, '0);
        if (qa.size() > 0 && qa[0].due <= cyc) begin
          chk("rsp_a_missing", bus_a.o_rsp_valid, 1);
          void'(qa.pop_front());
        end
      end
      if (bus_b.o_rsp_valid && qb.size() > 0) begin
        eb = qb.pop_front();
        chk("rsp_b_data", bus_b.o_rsp_rdata, eb.data);
        chk("rsp_b_cycle", cyc, eb.due);
      end else begin
        chk("rsp_b_idle", {bus_b.o_rsp_valid, bus_b.o_rsp_rdata}, '0);
        if (qb.size() > 0 && qb[0].due <= cyc) begin
          chk("rsp_b_missing", bus_b.o_rsp_valid, 1);
          void'(qb.pop_front());
        end
      end
      chk("rsp_c_idle", {bus_c.o_rsp_valid, bus_c.o_rsp_rdata}, '0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 0; valid = 0; we = 0; addr = '0; wdata = '0; c_start = 0;
    for (int i = 0; i < NW; i++) begin
      mem_a[i] <= GARB;
      mem_b[i] <= GARB;
      mem_c[i] <= GARB;
    end
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_a", outs_a, '0);
    chk("reset_b", outs_b, '0);
    chk("reset_c", outs_c, '0);
    mon_en = 1'b1;

    // Reset release: one IDLE cycle, then the 32-word sweep.
    step(); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_a", {bus_a.o_ram_cs, bus_a.o_init_busy}, 2'b00);
    step();
    sweep_ab("sweep1", NW);
    @(negedge clk);
    chk("post1_a", {bus_a.o_init_busy, bus_a.o_init_done, bus_a.o_req_ready, bus_a.o_ram_cs}, 4'b0110);
    chk("post1_b", {bus_b.o_init_busy, bus_b.o_init_done, bus_b.o_req_ready, bus_b.o_ram_cs}, 4'b0110);
    chk("c_idle1", {bus_c.o_init_busy, bus_c.o_init_done, bus_c.o_req_ready, bus_c.o_ram_cs}, 4'b0000);

    // dut_c: manual start; a second pulse at address 5 must not restart.
    step(); c_start = 1'b1;
    step(); c_start = 1'b0;
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      chk($sformatf("sweep_c_%0d", i),
          {bus_c.o_ram_cs, bus_c.o_ram_we, bus_c.o_init_busy, bus_c.o_req_ready,
           bus_c.o_init_done, bus_c.o_ram_addr, bus_c.o_ram_din},
          {5'b11100, AW'(i), C_INIT});
      step();
      c_start = (i == 4);
    end
    @(negedge clk);
    chk("post_c", {bus_c.o_init_busy, bus_c.o_init_done, bus_c.o_req_ready, bus_c.o_ram_cs}, 4'b0110);

    // Write 0xDEADBEEF to 7, then read it back.
    step(); valid = 1; we = 1; addr = 7; wdata = 64'hDEAD_BEEF;
    @(negedge clk);
    chk("wr_a", {bus_a.o_req_ready, bus_a.o_ram_cs, bus_a.o_ram_we, bus_a.o_ram_addr, bus_a.o_ram_din},
        {3'b111, 5'd7, 64'hDEAD_BEEF});
    chk("wr_b", {bus_b.o_req_ready, bus_b.o_ram_cs, bus_b.o_ram_we, bus_b.o_ram_addr, bus_b.o_ram_din},
        {3'b111, 5'd7, 64'hDEAD_BEEF});
    step(); we = 0;
    @(negedge clk);
    chk("rd7_a", {bus_a.o_req_ready, bus_a.o_ram_cs, bus_a.o_ram_we, bus_a.o_ram_addr}, {3'b110, 5'd7});
    push_read(64'hDEAD_BEEF);
    step(); valid = 0;
    repeat (4) step();

    // Back-to-back reads of 3, 4, 5.
    valid = 1; we = 0;
    for (int k = 0; k < 3; k++) begin
      addr = AW'(3 + k);
      @(negedge clk);
      chk($sformatf("b2b_a_%0d", k), {bus_a.o_req_ready, bus_a.o_ram_cs, bus_a.o_ram_addr}, {2'b11, AW'(3 + k)});
      chk($sformatf("b2b_b_%0d", k), {bus_b.o_req_ready, bus_b.o_ram_cs, bus_b.o_ram_addr}, {2'b11, AW'(3 + k)});
      push_read(64'd0);
      step();
    end
    valid = 0;
    repeat (4) step();

    // Read in flight, then init_start with a pending request.
    valid = 1; we = 0; addr = 7;
    @(negedge clk);
    push_read(64'hDEAD_BEEF);
    step(); start = 1; addr = 5;
    @(negedge clk);
    chk("start_a", {bus_a.o_req_ready, bus_a.o_ram_cs}, 2'b00);
    chk("start_b", {bus_b.o_req_ready, bus_b.o_ram_cs}, 2'b00);
    step(); start = 0; valid = 0;
    sweep_ab("sweep2", NW);
    @(negedge clk);
    chk("post2_a", {bus_a.o_init_busy, bus_a.o_init_done, bus_a.o_req_ready}, 3'b011);
    chk("post2_b", {bus_b.o_init_busy, bus_b.o_init_done, bus_b.o_req_ready}, 3'b011);
    step(); valid = 1; we = 0; addr = 7;
    @(negedge clk);
    push_read(64'd0);
    step(); valid = 0;
    repeat (4) step();

    // Reset mid-sweep at address 12; sweep must restart from 0.
    rst_n = 1'b0;
    step(); rst_n = 1'b1;
    step();
    sweep_ab("sweep3", 12);
    @(negedge clk);
    chk("at12_a", {bus_a.o_ram_cs, bus_a.o_ram_addr}, {1'b1, 5'd12});
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_a", outs_a, '0);
    chk("midrst_b", outs_b, '0);
    chk("midrst_c", outs_c, '0);
    step(); rst_n = 1'b1;
    step();
    sweep_ab("sweep4", NW);
    @(negedge clk);
    chk("post4_a", {bus_a.o_init_busy, bus_a.o_init_done, bus_a.o_req_ready}, 3'b011);
    chk("c_idle2", {bus_c.o_init_busy, bus_c.o_init_done, bus_c.o_req_ready, bus_c.o_ram_cs}, 4'b0000);

    repeat (5) step();
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
